// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Definitions shared by the debugger-unit blocks.
//   BYTE_W            - width of one byte on the UART path
//   DEBUG_DATA_WIDTH  - default pipeline snapshot width in bits
//   dbg_state_e       - state encoding of the snapshot transmit sequencer
// -----------------------------------------------------------------------------
package debug_pkg;

    localparam int BYTE_W           = 8;
    localparam int DEBUG_DATA_WIDTH = 2560;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dbg_state_e;

endpackage : debug_pkg

// File: rtl/debug_byte_select.sv
// -----------------------------------------------------------------------------
// debug_byte_select
// Combinational byte mux: picks byte i_idx out of a wide snapshot word.
// Byte 0 is bits [7:0]. An index beyond the last byte yields 0.
// Ports:
//   i_data  in  DATA_WIDTH  snapshot word
//   i_idx   in  IDX_W       byte index
//   o_byte  out 8           selected byte
// -----------------------------------------------------------------------------
module debug_byte_select
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = DEBUG_DATA_WIDTH,
    parameter int IDX_W      = $clog2(DATA_WIDTH / BYTE_W + 1)
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0]      i_idx,
    output logic [BYTE_W-1:0]     o_byte
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;

    logic [BYTE_W-1:0] lane [NUM_BYTES];

    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        assign lane[gi] = i_data[gi*BYTE_W +: BYTE_W];
    end

    // Compare-based selection keeps the out-of-range case well defined
    // (the checksum slot index sits one past the last data byte).
    always_comb begin
        o_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_byte = lane[i];
            end
        end
    end

endmodule : debug_byte_select

// File: rtl/debug_tx_sequencer.sv
// -----------------------------------------------------------------------------
// debug_tx_sequencer
// Dumps a captured pipeline snapshot to the UART transmitter one byte at a
// time, little-endian (bits [7:0] first), using the tx_start/tx_done
// handshake of the UART TX core.
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-low reset
//   is_send           in   one-cycle dump request (ignored unless idle)
//   i_data_from_pipe  in   live snapshot, captured when a request is accepted
//   is_tx_done        in   UART TX finished the current byte
//   o_tx_data         out  byte presented to UART TX
//   os_tx_start       out  one-cycle load pulse for UART TX
//   o_busy            out  high from accepted request through the done pulse
//   os_send_done      out  one-cycle pulse after the last byte completes
//   o_byte_index      out  index of the byte in flight
// Build option: define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte
// (sent with o_byte_index = NUM_BYTES) after the data bytes.
// -----------------------------------------------------------------------------
module debug_tx_sequencer
    import debug_pkg::*;
#(
    parameter  int DATA_WIDTH = DEBUG_DATA_WIDTH,
    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_W,
    localparam int IDX_W      = $clog2(NUM_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_send,
    input  logic [DATA_WIDTH-1:0] i_data_from_pipe,
    input  logic                  is_tx_done,
    output logic [BYTE_W-1:0]     o_tx_data,
    output logic                  os_tx_start,
    output logic                  o_busy,
    output logic                  os_send_done,
    output logic [IDX_W-1:0]      o_byte_index
);

`ifdef DEBUG_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
`endif

    dbg_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BYTE_W-1:0]     tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  send_done_q, send_done_d;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [BYTE_W-1:0]     csum_q, csum_d;
`endif

    logic [IDX_W-1:0]      next_idx;
    logic [BYTE_W-1:0]     next_byte;

    assign next_idx = idx_q + IDX_W'(1);

    // Outputs are registered, so the mux looks one byte ahead: the byte for
    // the next START is loaded on the same edge that samples is_tx_done.
    debug_byte_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_byte_select (
        .i_data (shadow_q),
        .i_idx  (next_idx),
        .o_byte (next_byte)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        busy_d      = busy_q;
        send_done_d = 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (is_send) begin
                    state_d    = ST_START;
                    shadow_d   = i_data_from_pipe;
                    idx_d      = '0;
                    // Shadow is only loaded on this edge, so byte 0 comes
                    // straight from the live bus.
                    tx_data_d  = i_data_from_pipe[BYTE_W-1:0];
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef DEBUG_TX_CHECKSUM_EN
                if (idx_q != IDX_W'(NUM_BYTES)) begin
                    csum_d = csum_q ^ tx_data_q;
                end
`endif
            end
            ST_WAIT: begin
                if (is_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_DONE;
                        send_done_d = 1'b1;
                    end else begin
                        state_d    = ST_START;
                        idx_d      = next_idx;
                        tx_start_d = 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                        // The last data byte was folded in during its START.
                        if (next_idx == IDX_W'(NUM_BYTES)) begin
                            tx_data_d = csum_q;
                        end else begin
                            tx_data_d = next_byte;
                        end
`else
                        tx_data_d  = next_byte;
`endif
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            send_done_q <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            send_done_q <= send_done_d;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign o_tx_data    = tx_data_q;
    assign os_tx_start  = tx_start_q;
    assign o_busy       = busy_q;
    assign os_send_done = send_done_q;
    assign o_byte_index = idx_q;

endmodule : debug_tx_sequencer

// File: tb/tb_debug_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_debug_tx_sequencer
// Two instances: a 32-bit one for the handshake scenarios and a 2560-bit one
// for the full-width dump. Honours DEBUG_TX_CHECKSUM_EN for the extra byte.
// -----------------------------------------------------------------------------
module tb_debug_tx_sequencer;

    localparam int SW   = 32;
    localparam int SNB  = SW / 8;
    localparam int SIW  = $clog2(SNB + 1);
    localparam int BW   = 2560;
    localparam int BNB  = BW / 8;
    localparam int BIW  = $clog2(BNB + 1);
`ifdef DEBUG_TX_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct {
        logic [31:0] snap;
        int          delay;
        bit          isolate;
        bit          inject;
        bit          with_done;
        logic [31:0] seq;    // expected bytes in transmit order, first byte in [31:24]
        logic [7:0]  csum;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;

    logic           s_send, s_done;
    logic [SW-1:0]  s_data;
    logic [7:0]     s_tx_data;
    logic           s_tx_start, s_busy, s_send_done;
    logic [SIW-1:0] s_idx;

    logic           b_send, b_done;
    logic [BW-1:0]  b_data;
    logic [7:0]     b_tx_data;
    logic           b_tx_start, b_busy, b_send_done;
    logic [BIW-1:0] b_idx;

    int             checks = 0;
    int             errors = 0;
    logic [7:0]     exp_q [$];

    always #5 clk = ~clk;

    debug_tx_sequencer #(.DATA_WIDTH(SW)) u_dut_small (
        .clk              (clk),
        .rst              (rst),
        .is_send          (s_send),
        .i_data_from_pipe (s_data),
        .is_tx_done       (s_done),
        .o_tx_data        (s_tx_data),
        .os_tx_start      (s_tx_start),
        .o_busy           (s_busy),
        .os_send_done     (s_send_done),
        .o_byte_index     (s_idx)
    );

    debug_tx_sequencer #(.DATA_WIDTH(BW)) u_dut_big (
        .clk              (clk),
        .rst              (rst),
        .is_send          (b_send),
        .i_data_from_pipe (b_data),
        .is_tx_done       (b_done),
        .o_tx_data        (b_tx_data),
        .os_tx_start      (b_tx_start),
        .o_busy           (b_busy),
        .os_send_done     (b_send_done),
        .o_byte_index     (b_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: bytes leave in ascending significance, then the XOR of all.
    task automatic model_dump(input logic [31:0] snap);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int k = 0; k < SNB; k++) begin
            b = 8'((snap >> (8 * k)) & 32'hFF);
            exp_q.push_back(b);
            x = x ^ b;
        end
        if (CSUM) exp_q.push_back(x);
    endtask

    task automatic table_dump(input logic [31:0] seq, input logic [7:0] csum);
        exp_q.delete();
        for (int k = 0; k < SNB; k++) exp_q.push_back(seq[31 - 8*k -: 8]);
        if (CSUM) exp_q.push_back(csum);
    endtask

    // One complete dump on the small DUT, UART answering 'delay' cycles after
    // each start. Inputs change and outputs are sampled on the falling edge.
    task automatic run_dump(input logic [31:0] snap, input int delay, input bit isolate,
                            input bit inject, input bit with_done, input bit b2b);
        int k         = 0;
        int due       = -1;
        int start_cyc = -1;
        int last_done = -1;
        bit finished  = 1'b0;
        if (!b2b) @(negedge clk);
        s_send = 1'b1;
        s_data = snap;
        s_done = with_done;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            s_send = 1'b0;
            s_done = 1'b0;
            if (isolate && cyc == 0) s_data = '1;
            if (s_tx_start) begin
                if (k < exp_q.size()) begin
                    chk("tx_data", s_tx_data, exp_q[k]);
                    chk("byte_index", s_idx, k);
                end else begin
                    chk("extra_tx_start", k, exp_q.size());
                end
                chk("busy_in_dump", s_busy, 1);
                if (k == 0) chk("first_start_latency", cyc, 0);
                else        chk("start_latency", cyc - last_done, 1);
                start_cyc = cyc;
                due       = cyc + delay;
                k++;
                if (inject && k == 1) s_done = 1'b1;       // tx_done during START
            end
            if (inject && k == 2 && cyc == start_cyc + 1) s_send = 1'b1;  // send during WAIT
            if (cyc == due) begin
                s_done    = 1'b1;
                last_done = cyc;
            end
            if (s_send_done) begin
                chk("send_done_latency", cyc - last_done, 1);
                chk("byte_count", k, exp_q.size());
                chk("busy_at_done", s_busy, 1);
                finished = 1'b1;
            end
        end
        chk("dump_finished", finished, 1);
        @(negedge clk);
        chk("busy_after_done", s_busy, 0);
        chk("send_done_pulse", s_send_done, 0);
        chk("tx_start_after_done", s_tx_start, 0);
        if (exp_q.size() > 0) chk("tx_data_held", s_tx_data, exp_q[exp_q.size() - 1]);
        $display("dump snap=0x%08h delay=%0d bytes=%0d", snap, delay, k);
    endtask

    task automatic reset_mid();
        bit hit   = 1'b0;
        int due   = -1;
        int extra = 0;
        @(negedge clk);
        s_send = 1'b1;
        s_data = 32'h44332211;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            s_send = 1'b0;
            s_done = 1'b0;
            if (s_tx_start) begin
                if (s_idx == SIW'(2)) hit = 1'b1;
                else                  due = cyc + 2;
            end
            if (cyc == due) s_done = 1'b1;
        end
        chk("reset_reached_byte2", hit, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_tx_data", s_tx_data, 0);
        chk("abort_tx_start", s_tx_start, 0);
        chk("abort_busy", s_busy, 0);
        chk("abort_send_done", s_send_done, 0);
        chk("abort_index", s_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            extra += int'(s_send_done) + int'(s_tx_start) + int'(s_busy);
        end
        chk("quiet_after_abort", extra, 0);
        $display("reset abort during byte 2");
        table_dump(32'h11223344, 8'h44);
        run_dump(32'h44332211, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic big_dump();
        int         k         = 0;
        int         due       = -1;
        bit         finished  = 1'b0;
        logic [7:0] e;
        b_data          = '0;
        b_data[3:0]     = 4'hF;
        b_data[BW-1]    = 1'b1;
        @(negedge clk);
        b_send = 1'b1;
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            @(negedge clk);
            b_send = 1'b0;
            b_done = 1'b0;
            if (b_tx_start) begin
                e = 8'h00;
                if (k == 0)            e = 8'h0F;
                else if (k == BNB - 1) e = 8'h80;
                else if (k == BNB)     e = 8'h8F;
                chk("big_tx_data", b_tx_data, e);
                chk("big_index", b_idx, k);
                due = cyc + 1 + (k % 3);
                k++;
            end
            if (cyc == due) b_done = 1'b1;
            if (b_send_done) finished = 1'b1;
        end
        chk("big_finished", finished, 1);
        chk("big_count", k, CSUM ? BNB + 1 : BNB);
        $display("dump width=%0d bytes=%0d", BW, k);
    endtask

    initial begin
        vec_t        vecs [6];
        logic [31:0] snap;

        vecs[0] = '{32'h44332211, 5, 1'b0, 1'b0, 1'b0, 32'h11223344, 8'h44};
        vecs[1] = '{32'h44332211, 5, 1'b1, 1'b0, 1'b0, 32'h11223344, 8'h44};
        vecs[2] = '{32'h44332211, 3, 1'b0, 1'b1, 1'b0, 32'h11223344, 8'h44};
        vecs[3] = '{32'h01020408, 1, 1'b1, 1'b1, 1'b1, 32'h08040201, 8'h0F};
        vecs[4] = '{32'h80000001, 2, 1'b0, 1'b0, 1'b1, 32'h01000080, 8'h81};
        vecs[5] = '{32'hA5A55A5A, 4, 1'b0, 1'b1, 1'b0, 32'h5A5AA5A5, 8'h00};

        rst    = 1'b0;
        s_send = 1'b0;
        s_done = 1'b0;
        s_data = '0;
        b_send = 1'b0;
        b_done = 1'b0;
        b_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_tx_data", s_tx_data, 0);
        chk("reset_tx_start", s_tx_start, 0);
        chk("reset_busy", s_busy, 0);
        chk("reset_send_done", s_send_done, 0);
        chk("reset_index", s_idx, 0);
        rst = 1'b1;
        @(negedge clk);

        // tx_done while idle must not move anything
        s_done = 1'b1;
        @(negedge clk);
        s_done = 1'b0;
        chk("idle_done_busy", s_busy, 0);
        chk("idle_done_start", s_tx_start, 0);
        chk("idle_done_index", s_idx, 0);

        for (int i = 0; i < 6; i++) begin
            table_dump(vecs[i].seq, vecs[i].csum);
            run_dump(vecs[i].snap, vecs[i].delay, vecs[i].isolate, vecs[i].inject,
                     vecs[i].with_done, 1'b0);
        end

        reset_mid();

        for (int i = 0; i < 24; i++) begin
            snap = $urandom;
            model_dump(snap);
            run_dump(snap, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        big_dump();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debug_tx_sequencer

// File: doc/debug_tx_sequencer.md
Name: debug_tx_sequencer

Overview:
- Debugger-unit block that dumps a wide pipeline snapshot to the host over the UART transmitter, one byte at a time.
- Sits between the pipeline snapshot bus (i_data_from_pipe) and the UART TX core. It owns the is_tx_done/os_tx_start handshake.
- The top-level debug FSM only issues a send request and waits for completion.

Parameters:
- DATA_WIDTH, 2560: snapshot width in bits; must be a multiple of 8.
- NUM_BYTES, DATA_WIDTH/8 (localparam): number of data bytes per dump.
- IDX_W, $clog2(NUM_BYTES+1) (localparam): width of the byte index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- is_send  in  1  one-cycle request to start a dump.
- i_data_from_pipe  in  DATA_WIDTH  live pipeline snapshot.
- is_tx_done  in  1  one-cycle pulse from UART TX: current byte finished.
- o_tx_data  out  8  byte presented to UART TX.
- os_tx_start  out  1  one-cycle pulse: UART TX loads o_tx_data.
- o_busy  out  1  high from request accepted until the done pulse, inclusive.
- os_send_done  out  1  one-cycle pulse after the last byte completes.
- o_byte_index  out  IDX_W  index of the byte currently in flight.

Behaviour:
- Reset (rst=0, asynchronous), all registered:
  - state=IDLE.
  - Outputs o_tx_data=0, os_tx_start=0, o_busy=0, os_send_done=0, o_byte_index=0.
  - Internal shadow register=0.
- States:
  - IDLE -> START: on an edge with is_send=1. The shadow register captures i_data_from_pipe at that same edge; later pipeline changes do not affect the dump. o_byte_index=0, o_busy=1.
  - START, one cycle:
    - os_tx_start=1.
    - o_tx_data = shadow[8*idx+7 : 8*idx]; byte 0 = bits [7:0] is sent first (little-endian).
    - Next state WAIT.
  - WAIT: hold o_tx_data and o_byte_index; os_tx_start=0. On is_tx_done=1:
    - idx == last: go to DONE.
    - otherwise: idx+1 and go to START.
  - DONE, one cycle: os_send_done=1, o_busy=1. Next state IDLE, with o_busy=0 in the following cycle.
- Latency:
  - First os_tx_start occurs in the cycle immediately after the edge that samples is_send.
  - Each subsequent os_tx_start occurs one cycle after the sampled is_tx_done.
- Boundary conditions:
  - is_send while not IDLE: ignored, not queued.
  - is_tx_done outside WAIT, including during START: ignored.
  - is_send and is_tx_done together in IDLE: the dump starts; is_tx_done is ignored.
  - Reset mid-dump: immediate abort to the reset values. No os_send_done is produced. The next is_send starts again at byte 0.
  - o_tx_data keeps the last byte after DONE; it is not cleared.
  - Back-to-back: is_send asserted in the cycle after os_send_done is accepted.

Optional Feature:
- Macro: DEBUG_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR checksum register is cleared on capture.
  - It XORs in each data byte as that byte is issued in START.
  - After data byte NUM_BYTES-1 completes, one extra START/WAIT pair sends the checksum with o_byte_index=NUM_BYTES. DONE follows its is_tx_done.
- Undefined: exactly NUM_BYTES bytes are sent; no checksum logic exists; o_byte_index never exceeds NUM_BYTES-1.

Decomposition:
- Shared package debug_pkg:
  - state encoding (IDLE, START, WAIT, DONE);
  - BYTE_W=8;
  - the default snapshot width constant used by the other debug-unit blocks.
- One natural sub-module, debug_byte_select: combinational DATA_WIDTH-to-8 mux indexed by o_byte_index. It keeps the wide mux separate from the FSM for synthesis review.

Test Plan:
- Basic dump: DATA_WIDTH=32, i_data_from_pipe=0x44332211, is_send pulse, bench returns is_tx_done 5 cycles after each os_tx_start.
  -> Exactly 4 os_tx_start pulses with o_tx_data 0x11, 0x22, 0x33, 0x44.
  -> os_send_done one cycle after the 4th is_tx_done; o_busy low after that.
- Snapshot isolation: change i_data_from_pipe to 0xFFFFFFFF one cycle after is_send.
  -> Bytes sent are still 0x11, 0x22, 0x33, 0x44.
- Ignored events:
  - is_send pulse during WAIT of byte 1 -> no restart.
  - is_tx_done pulse in IDLE and in START -> no index advance.
  -> Total of 4 bytes only.
- Reset mid-operation: rst=0 during WAIT of byte 2.
  -> All outputs 0 and no os_send_done.
  -> A new is_send then restarts at byte 0 (0x11).
- Full width: DATA_WIDTH=2560, bits [3:0]=1 and bit 2559=1.
  -> 320 os_tx_start pulses; byte 0 = 0x0F, byte 319 = 0x80, all others 0x00.
- Checksum: with DEBUG_TX_CHECKSUM_EN, data 0x44332211.
  -> 5th byte = 0x44 (0x11^0x22^0x33^0x44) with o_byte_index=4.
  -> os_send_done after the 5th is_tx_done.
